addsub_serial: RTL and testbench

- Parametrised multi-cycle N-bit adder/subtractor built from a W-bit chunk adder.
- Processes W bits per clock, so N/W cycles per operation.
- Uses a start/busy/done handshake and produces carry, overflow, zero and negative flags.
- Sits in the ALU datapath where a full-width ripple adder is too slow or too large. Area and latency trade off through W.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 30 +++
 rtl/addsub_serial.sv | 117 +++++++++++
 tb/tb_addsub_serial.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package addsub_pkg;

   // Operation sequencing: wait for a request, walk the chunks, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Values of op_sub.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Width of a counter that must hold 0..k-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// W-bit combinational ripple-carry adder slice, also exposing the carry into its top bit.
module adder_chunk #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   // Full-adder ripple; c_msb is captured just before the top bit consumes it.
   always_comb begin : p_ripple
      logic carry;
      sum   = '0;
      cout  = 1'b0;
      c_msb = 1'b0;
      carry = cin;
      for (int i = 0; i < int'(W); i++) begin
         if (i == int'(W) - 1) begin
            c_msb = carry;
         end
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle N-bit adder/subtractor that consumes W bits per clock through one chunk adder.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op_sub,
   input  logic [N-1:0] operand_a,
   input  logic [N-1:0] operand_b,
   input  logic         carry_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         carry_out,
   output logic         overflow,
   output logic         zero,
   output logic         negative
);

   localparam int unsigned K  = N / W;
   localparam int unsigned CW = cnt_width(K);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   // Chunk width must tile the operand exactly.
   if (W < 1 || W > N || (N % W) != 0) begin : g_cfg_err
      $error("addsub_serial: N must be a non-zero multiple of W with 1 <= W <= N");
   end

   state_t        state;
   logic [N-1:0]  a_sr;
   logic [N-1:0]  b_sr;
   logic [N-1:0]  res_sr;
   logic          carry;
   logic [CW-1:0] k_cnt;

   logic [W-1:0]  chunk_sum;
   logic          chunk_cout;
   logic          chunk_cmsb;
   logic [N-1:0]  res_next;

   // The single chunk adder always works on the low W bits of the operand shifters.
   adder_chunk #(
      .W(W)
   ) u_chunk (
      .a     (a_sr[W-1:0]),
      .b     (b_sr[W-1:0]),
      .cin   (carry),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_msb (chunk_cmsb)
   );

   // New chunk sum enters at the top; after K chunks chunk 0 sits at the bottom.
   assign res_next = (res_sr >> W) | (N'(chunk_sum) << (N - W));

   // Sequencer, operand/result shifters and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         carry     <= 1'b0;
         k_cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr   <= operand_a;
                  b_sr   <= (op_sub == OP_ADD) ? operand_b : ~operand_b;
                  carry  <= (op_sub == OP_SUB) ? 1'b1 : carry_in;
                  res_sr <= '0;
                  k_cnt  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> W;
               b_sr   <= b_sr >> W;
               res_sr <= res_next;
               carry  <= chunk_cout;
               k_cnt  <= k_cnt + CW'(1);
               if (k_cnt == LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result    <= res_next;
                  carry_out <= chunk_cout;
                  overflow  <= chunk_cmsb ^ chunk_cout;
                  zero      <= (res_next == '0);
                  negative  <= res_next[N-1];
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: directed table and corner sequences on N=8/W=2, random sweep on other shapes.
module tb_addsub_serial;

   localparam int unsigned N = 8;
   localparam int unsigned W = 2;
   localparam int unsigned K = N / W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rst_sw;
   logic         start;
   logic         op_sub;
   logic [N-1:0] operand_a;
   logic [N-1:0] operand_b;
   logic         carry_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         negative;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int sweep_fin = 0;

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] r;
      logic [3:0] f;    // {carry_out, overflow, zero, negative}
   } vec_t;

   typedef struct {
      logic [7:0] r;
      logic [3:0] f;
      int         due;
   } exp_t;

   typedef struct {
      logic [31:0] r;
      logic        co;
      logic        ov;
      logic        z;
      logic        ng;
   } ref_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] last_r = 8'h00;
   vec_t       vecs[10];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   addsub_serial #(
      .N(N),
      .W(W)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_sub    (op_sub),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: modulo-2^n add with signed overflow from operand/result signs.
   function automatic ref_t ref_calc(input int n, input logic [31:0] a, input logic [31:0] b,
                                     input logic sub, input logic ci);
      ref_t        o;
      logic [32:0] mask;
      logic [32:0] aa;
      logic [32:0] bb;
      logic [32:0] s;
      mask = (33'd1 << n) - 33'd1;
      aa   = {1'b0, a} & mask;
      bb   = sub ? ({1'b0, ~b} & mask) : ({1'b0, b} & mask);
      s    = aa + bb + 33'(sub ? 1'b1 : ci);
      o.r  = s[31:0] & mask[31:0];
      o.co = s[n];
      o.ov = (aa[n-1] == bb[n-1]) && (o.r[n-1] != aa[n-1]);
      o.z  = (o.r == 32'd0);
      o.ng = o.r[n-1];
      return o;
   endfunction

   // Scoreboard monitor for the main instance.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", 64'(result), 64'(mon_e.r));
            check("flags", 64'({carry_out, overflow, zero, negative}), 64'(mon_e.f));
            check("latency", 64'(cyc), 64'(mon_e.due));
            check("busy_at_done", 64'(busy), 64'd0);
            last_r = mon_e.r;
         end
      end
   end

   task automatic issue(input logic sub, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic push, input logic [7:0] er, input logic [3:0] ef);
      exp_t e;
      @(negedge clk);
      start     = 1'b1;
      op_sub    = sub;
      operand_a = a;
      operand_b = b;
      carry_in  = ci;
      if (push) begin
         e.r   = er;
         e.f   = ef;
         e.due = cyc + 1 + int'(K);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      operand_a = ~a;
      operand_b = ~b;
      carry_in  = ~ci;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Random sweep over other widths, each instance with its own driver.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
      localparam int unsigned GN = (gi == 3) ? 16 : 8;
      localparam int unsigned GW = (gi == 0) ? 1 : ((gi == 2) ? 8 : 4);
      localparam int unsigned GK = GN / GW;

      logic          s_start;
      logic          s_sub;
      logic          s_ci;
      logic          s_busy;
      logic          s_done;
      logic          s_co;
      logic          s_ov;
      logic          s_z;
      logic          s_ng;
      logic [GN-1:0] s_a;
      logic [GN-1:0] s_b;
      logic [GN-1:0] s_r;

      addsub_serial #(
         .N(GN),
         .W(GW)
      ) u_sw (
         .clk       (clk),
         .rst_n     (rst_sw),
         .start     (s_start),
         .op_sub    (s_sub),
         .operand_a (s_a),
         .operand_b (s_b),
         .carry_in  (s_ci),
         .busy      (s_busy),
         .done      (s_done),
         .result    (s_r),
         .carry_out (s_co),
         .overflow  (s_ov),
         .zero      (s_z),
         .negative  (s_ng)
      );

      initial begin
         ref_t        e;
         int          n;
         logic [31:0] ra;
         logic [31:0] rb;
         s_start = 1'b0;
         s_sub   = 1'b0;
         s_ci    = 1'b0;
         s_a     = '0;
         s_b     = '0;
         @(posedge rst_sw);
         for (int t = 0; t < 1000; t++) begin
            ra = $urandom;
            rb = $urandom;
            @(negedge clk);
            s_start = 1'b1;
            s_sub   = 1'($urandom_range(0, 1));
            s_ci    = 1'($urandom_range(0, 1));
            s_a     = GN'(ra);
            s_b     = GN'(rb);
            e = ref_calc(int'(GN), 32'(s_a), 32'(s_b), s_sub, s_ci);
            @(posedge clk);
            #1;
            s_start = 1'b0;
            s_a     = ~s_a;
            s_b     = ~s_b;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!s_done && n < int'(GK) + 6);
            check($sformatf("sw%0d_latency", gi), 64'(n), 64'(GK + 1));
            if (s_done) begin
               check($sformatf("sw%0d_result", gi), 64'(s_r), 64'(e.r[GN-1:0]));
               check($sformatf("sw%0d_flags", gi), 64'({s_co, s_ov, s_z, s_ng}),
                     64'({e.co, e.ov, e.z, e.ng}));
            end
         end
         sweep_fin++;
      end
   end

   initial begin
      int n;
      vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 4'b0101};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010};
      vecs[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0101};
      vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 4'b0001};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1100};
      vecs[5] = '{1'b1, 8'h55, 8'h55, 1'b1, 8'h00, 4'b1010};
      vecs[6] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 4'b1001};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000};
      vecs[8] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0001};
      vecs[9] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b0101};

      rst_n     = 1'b0;
      rst_sw    = 1'b0;
      start     = 1'b0;
      op_sub    = 1'b0;
      operand_a = 8'hA5;
      operand_b = 8'h5A;
      carry_in  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({busy, done, result, carry_out, overflow, zero, negative}), 64'd0);
      rst_n  = 1'b1;
      rst_sw = 1'b1;

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1, vecs[i].r, vecs[i].f);
         wait_drain();
      end

      // Start mid-run is ignored and the previous result holds until done.
      issue(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 4'b0000);
      repeat (2) @(negedge clk);
      check("hold_mid_run", 64'(result), 64'(last_r));
      start     = 1'b1;
      op_sub    = 1'b1;
      operand_a = 8'hF0;
      operand_b = 8'h0F;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();

      // Start in the DONE cycle is accepted back to back.
      issue(1'b0, 8'hC8, 8'h64, 1'b0, 1'b1, 8'h2C, 4'b1000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_wait_timeout actual=0 required=1");
      end else begin
         start     = 1'b1;
         op_sub    = 1'b1;
         operand_a = 8'h05;
         operand_b = 8'h0A;
         carry_in  = 1'b0;
         sb_q.push_back('{8'hFB, 4'b0001, cyc + 1 + int'(K)});
         @(posedge clk);
         #1;
         start = 1'b0;
         check("accept_in_done", 64'(busy), 64'd1);
      end
      wait_drain();

      // Reset during chunk 2 aborts the operation with no done.
      issue(1'b1, 8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 4'b0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_mid_run", 64'({busy, done, result, carry_out, overflow, zero, negative}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      issue(1'b1, 8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 4'b1000);
      wait_drain();

      n = 0;
      while (sweep_fin < 4 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (sweep_fin < 4) begin
         total++;
         bad++;
         $display("FAIL sweep_timeout actual=%0d required=4", sweep_fin);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
